// File: rtl/bus_master_pkg.sv
// bus_master_pkg: state codes and constants shared by the burst read master files.
package bus_master_pkg;
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_REQUEST = 3'd1;
   localparam state_t ST_BEGIN   = 3'd2;
   localparam state_t ST_WAIT    = 3'd3;
   localparam state_t ST_ABORT   = 3'd4;
   localparam logic [3:0] BYTE_ENABLES_ALL = 4'hF;
   localparam int MAX_BURST_WORDS = 256;
   localparam int BEAT_WIDTH = $clog2(MAX_BURST_WORDS + 1);
endpackage

// File: rtl/bus_master_watchdog.sv
// bus_master_watchdog: loadable down-counter that flags a run of timeoutCycles idle ticks.
module bus_master_watchdog #(
   parameter int timeoutCycles = 1023,
   parameter int timeoutWidth = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic tick,
   output logic expire
);
   localparam logic [timeoutWidth-1:0] RELOAD = timeoutWidth'(timeoutCycles);
   logic [timeoutWidth-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (load) cnt <= RELOAD;
      else if (tick && cnt != '0) cnt <= cnt - timeoutWidth'(1);
   // cnt holds the idle ticks still allowed, so reaching 1 marks the last one
   assign expire = tick && !load && cnt == timeoutWidth'(1);
endmodule

// File: rtl/bus_burst_read_master.sv
// bus_burst_read_master: arbitrates for the wired-OR bus, issues one read burst and
// streams the returned words to a local consumer, reporting done or error.
module bus_burst_read_master
   import bus_master_pkg::*;
#(
   parameter int timeoutCycles = 1023,
   parameter int timeoutWidth = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] startAddress,
   input  logic [7:0]  burstLength,
   output logic        busyOut,
   output logic        donePulse,
   output logic        errorPulse,
   output logic [31:0] wordOut,
   output logic        wordValid,
   output logic [7:0]  wordIndex,
   output logic        requestTransaction,
   input  logic        transactionGranted,
   output logic        beginTransactionOut,
   output logic [31:0] addressDataOut,
   output logic [3:0]  byteEnablesOut,
   output logic        readNotWriteOut,
   output logic [7:0]  burstSizeOut,
   output logic        endTransactionOut,
   input  logic [31:0] addressDataIn,
   input  logic        dataValidIn,
   input  logic        endTransactionIn,
   input  logic        busErrorIn
);
   state_t state, state_nxt;
   logic [31:2] addr;
   logic [7:0] len;
   logic [BEAT_WIDTH-1:0] beat_cnt, cnt_nxt, beats_due;
   logic overrun, ovr_nxt, done_r, err_r, expire;
   logic in_wait, beat, fits, fwd, finish, ok, unused_bits;

   assign in_wait = state == ST_WAIT;
   assign beat = in_wait && dataValidIn && !busErrorIn;
   assign beats_due = BEAT_WIDTH'(len) + BEAT_WIDTH'(1);
   assign fits = beat_cnt < beats_due;
   assign fwd = beat && fits;
   assign cnt_nxt = beat_cnt + BEAT_WIDTH'(fwd);
   assign ovr_nxt = overrun || (beat && !fits);
   // the end strobe is judged against the count that includes its own beat
   assign finish = in_wait && !busErrorIn && endTransactionIn;
   assign ok = cnt_nxt == beats_due && !ovr_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    state_nxt = start ? ST_REQUEST : ST_IDLE;
         ST_REQUEST: state_nxt = transactionGranted ? ST_BEGIN : ST_REQUEST;
         ST_BEGIN:   state_nxt = ST_WAIT;
         ST_WAIT:    state_nxt = busErrorIn ? ST_ABORT : endTransactionIn ? ST_IDLE : expire ? ST_ABORT : ST_WAIT;
         ST_ABORT:   state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= ST_IDLE;
         addr <= '0;
         len <= '0;
         beat_cnt <= '0;
         overrun <= 1'b0;
         wordValid <= 1'b0;
         wordOut <= '0;
         wordIndex <= '0;
         done_r <= 1'b0;
         err_r <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            addr <= startAddress[31:2];
            len <= burstLength;
         end
         beat_cnt <= state == ST_IDLE ? '0 : cnt_nxt;
         overrun <= state != ST_IDLE && ovr_nxt;
         wordValid <= fwd;
         if (fwd) begin
            wordOut <= addressDataIn;
            wordIndex <= beat_cnt[7:0];
         end
         done_r <= finish && ok;
         err_r <= finish && !ok;
      end

   bus_master_watchdog #(
      .timeoutCycles(timeoutCycles),
      .timeoutWidth(timeoutWidth)
   ) u_watchdog (
      .clk(clock),
      .rst(reset),
      .load(state == ST_BEGIN || beat),
      .tick(in_wait),
      .expire(expire)
   );

   assign busyOut = state != ST_IDLE;
   assign requestTransaction = state != ST_IDLE;
   assign beginTransactionOut = state == ST_BEGIN;
   assign addressDataOut = beginTransactionOut ? {addr, 2'b00} : '0;
   assign byteEnablesOut = beginTransactionOut ? BYTE_ENABLES_ALL : '0;
   assign readNotWriteOut = beginTransactionOut;
   assign burstSizeOut = beginTransactionOut ? len : '0;
   assign endTransactionOut = state == ST_ABORT;
   assign donePulse = done_r;
   assign errorPulse = err_r || endTransactionOut;
   assign unused_bits = ^startAddress[1:0];
endmodule

// File: tb/tb_bus_burst_read_master.sv
// tb_bus_burst_read_master: directed and randomised bursts checked against a burst-level model.
module tb_bus_burst_read_master;
   localparam int TIMEOUT = 1023;
   logic clock = 0, reset = 1, start = 0;
   logic [31:0] startAddress = 0;
   logic [7:0] burstLength = 0;
   logic transactionGranted = 0, dataValidIn = 0, endTransactionIn = 0, busErrorIn = 0;
   logic [31:0] addressDataIn = 0;
   logic busyOut, donePulse, errorPulse, wordValid, requestTransaction;
   logic beginTransactionOut, readNotWriteOut, endTransactionOut;
   logic [31:0] wordOut, addressDataOut;
   logic [7:0] wordIndex, burstSizeOut;
   logic [3:0] byteEnablesOut;
   int checks = 0, failures = 0;

   bus_burst_read_master #(.timeoutCycles(TIMEOUT), .timeoutWidth(10)) dut (
      .clock(clock), .reset(reset), .start(start), .startAddress(startAddress),
      .burstLength(burstLength), .busyOut(busyOut), .donePulse(donePulse),
      .errorPulse(errorPulse), .wordOut(wordOut), .wordValid(wordValid),
      .wordIndex(wordIndex), .requestTransaction(requestTransaction),
      .transactionGranted(transactionGranted), .beginTransactionOut(beginTransactionOut),
      .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
      .readNotWriteOut(readNotWriteOut), .burstSizeOut(burstSizeOut),
      .endTransactionOut(endTransactionOut), .addressDataIn(addressDataIn),
      .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn)
   );

   always #5 clock = ~clock;

   int cyc = 0, n_begin, n_endt, n_done, n_err, begin_cyc, endt_cyc;
   int bus_viol = 0, both_viol = 0;
   logic [31:0] b_addr;
   logic [3:0] b_be;
   logic b_rnw;
   logic [7:0] b_size;
   logic [31:0] got_w[$];
   logic [7:0] got_i[$];
   int wv_cyc[$], dv_cyc[$];

   always @(negedge clock) begin
      cyc++;
      if (wordValid) begin
         got_w.push_back(wordOut);
         got_i.push_back(wordIndex);
         wv_cyc.push_back(cyc);
      end
      if (dataValidIn) dv_cyc.push_back(cyc);
      if (beginTransactionOut) begin
         n_begin++;
         b_addr = addressDataOut;
         b_be = byteEnablesOut;
         b_rnw = readNotWriteOut;
         b_size = burstSizeOut;
         begin_cyc = cyc;
      end
      if (endTransactionOut) begin
         n_endt++;
         endt_cyc = cyc;
      end
      n_done += int'(donePulse);
      n_err += int'(errorPulse);
      if ((!beginTransactionOut && (addressDataOut != 0 || byteEnablesOut != 0 || readNotWriteOut || burstSizeOut != 0)) ||
          (!requestTransaction && (beginTransactionOut || endTransactionOut)))
         bus_viol++;
      if (donePulse && errorPulse) both_viol++;
   end

   function automatic logic [91:0] outs();
      return {busyOut, donePulse, errorPulse, wordOut, wordValid, wordIndex, requestTransaction,
              beginTransactionOut, addressDataOut, byteEnablesOut, readNotWriteOut, burstSizeOut, endTransactionOut};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got_w.delete();
      got_i.delete();
      wv_cyc.delete();
      dv_cyc.delete();
      n_begin = 0;
      n_endt = 0;
      n_done = 0;
      n_err = 0;
      begin_cyc = 0;
      endt_cyc = 0;
   endtask

   // mode 0: responder ends normally, 1: bus error on last driven beat, 2: responder silent
   task automatic run_burst(input string tag, input logic [31:0] a, input logic [7:0] l, input int gdelay,
                            input int nbeats, input int mode, input int maxgap, input bit join_end);
      logic [31:0] data[$];
      int fwd, waited, due;
      bit exp_done;
      clear_mon();
      due = int'(l) + 1;
      startAddress = a;
      burstLength = l;
      start = 1;
      step();
      start = 0;
      repeat (gdelay) step();
      transactionGranted = 1;
      waited = 0;
      while (!beginTransactionOut && waited < 20) begin
         step();
         waited++;
      end
      transactionGranted = 0;
      check({tag, ".begin_seen"}, beginTransactionOut, 1);
      step();
      for (int i = 0; i < nbeats; i++) begin
         repeat ($urandom_range(maxgap, 0)) step();
         data.push_back($urandom);
         addressDataIn = data[data.size() - 1];
         dataValidIn = 1;
         busErrorIn = mode == 1 && i == nbeats - 1;
         endTransactionIn = mode == 0 && join_end && i == nbeats - 1;
         step();
         dataValidIn = 0;
         busErrorIn = 0;
         endTransactionIn = 0;
      end
      if (mode == 0 && (!join_end || nbeats == 0)) begin
         endTransactionIn = 1;
         step();
         endTransactionIn = 0;
      end
      waited = 0;
      while (busyOut && waited < 1500) begin
         step();
         waited++;
      end
      check({tag, ".idle"}, busyOut, 0);
      repeat (2) step();
      fwd = mode == 2 ? 0 : mode == 1 ? nbeats - 1 : nbeats;
      if (fwd > due) fwd = due;
      exp_done = mode == 0 && nbeats == due;
      check({tag, ".n_begin"}, n_begin, 1);
      check({tag, ".begin_addr"}, b_addr, {a[31:2], 2'b00});
      check({tag, ".begin_be"}, b_be, 4'hF);
      check({tag, ".begin_rnw"}, b_rnw, 1);
      check({tag, ".begin_size"}, b_size, l);
      check({tag, ".n_words"}, got_w.size(), fwd);
      for (int k = 0; k < fwd && k < got_w.size(); k++) begin
         check($sformatf("%s.word%0d", tag, k), {got_i[k], got_w[k]}, {8'(k), data[k]});
         check($sformatf("%s.lat%0d", tag, k), wv_cyc[k], dv_cyc[k] + 1);
      end
      check({tag, ".done"}, n_done, exp_done);
      check({tag, ".error"}, n_err, !exp_done);
      check({tag, ".n_endt"}, n_endt, mode != 0);
      if (mode == 1) check({tag, ".abort_lat"}, endt_cyc, dv_cyc[dv_cyc.size() - 1] + 1);
      if (mode == 2) check({tag, ".timeout"}, endt_cyc - begin_cyc, TIMEOUT + 1);
      check({tag, ".req_drop"}, requestTransaction, 0);
   endtask

   initial begin
      int waited, l, n, sel;
      repeat (3) @(posedge clock);
      #1;
      check("reset_outs", outs(), 0);
      reset = 0;
      step();
      run_burst("basic", 32'h0000_1006, 8'd3, 2, 4, 0, 0, 1'b0);
      run_burst("full256", $urandom, 8'd255, 1, 256, 0, 0, 1'b1);
      run_burst("short", $urandom, 8'd3, 0, 2, 0, 1, 1'b0);
      run_burst("buserr", $urandom, 8'd3, 1, 2, 1, 0, 1'b0);
      run_burst("timeout", $urandom, 8'd3, 0, 0, 2, 0, 1'b0);

      // asynchronous reset in the middle of a burst, then restart straight away
      clear_mon();
      startAddress = 32'h0000_2000;
      burstLength = 8'd3;
      start = 1;
      step();
      start = 0;
      transactionGranted = 1;
      step();
      transactionGranted = 0;
      step();
      addressDataIn = 32'hCAFE_F00D;
      dataValidIn = 1;
      step();
      dataValidIn = 0;
      check("rst.pre_wordvalid", wordValid, 1);
      #2 reset = 1;
      #1 check("rst.async_outs", outs(), 0);
      step();
      reset = 0;
      step();
      clear_mon();
      startAddress = 32'h0000_3008;
      burstLength = 8'd1;
      start = 1;
      step();
      start = 0;
      check("rst.start_accepted", busyOut, 1);
      startAddress = 32'hFFFF_FFF0;
      burstLength = 8'd7;
      start = 1;
      step();
      start = 0;
      transactionGranted = 1;
      waited = 0;
      while (!beginTransactionOut && waited < 20) begin
         step();
         waited++;
      end
      transactionGranted = 0;
      check("rst.begin_addr", addressDataOut, 32'h0000_3008);
      check("rst.begin_size", burstSizeOut, 8'd1);
      step();
      dataValidIn = 1;
      addressDataIn = 32'h1111_2222;
      step();
      addressDataIn = 32'h3333_4444;
      endTransactionIn = 1;
      step();
      dataValidIn = 0;
      endTransactionIn = 0;
      repeat (2) step();
      check("rst.n_words", got_w.size(), 2);
      check("rst.done", n_done, 1);
      check("rst.error", n_err, 0);
      check("rst.no_endt", n_endt, 0);

      for (int r = 0; r < 8; r++) begin
         l = int'($urandom_range(15, 0));
         sel = int'($urandom_range(3, 0));
         n = sel < 2 ? l + 1 : sel == 2 ? int'($urandom_range(l, 0)) : l + 1 + int'($urandom_range(3, 1));
         run_burst($sformatf("rand%0d", r), $urandom, 8'(l), int'($urandom_range(4, 0)), n, 0, 3,
                   1'($urandom_range(1, 0)));
      end
      check("bus_zero_when_idle", bus_viol, 0);
      check("done_error_exclusive", both_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation did not finish");
   end
endmodule

// File: doc/bus_burst_read_master.md
Name: bus_burst_read_master

Overview:
- Single-channel bus initiator. It is the requesting end of the shared system bus whose responders include the SDRAM controller.
- On a local start command it arbitrates for the bus, issues one read burst of up to 256 words, and streams the returned words to a local consumer (camera/DMA-style engines, test harness).
- It reports done or error and, on error, releases the bus cleanly.
- All bus outputs are 0 whenever the block does not own the bus, because the bus is wired-OR.

Parameters:
- timeoutCycles, 1023: idle cycles allowed between begin or data beats before self-abort.
- timeoutWidth, 10: width of the watchdog counter. Must satisfy timeoutWidth ≥ clog2(timeoutCycles+1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle command pulse.
- startAddress  in  32  byte address of first word. Bits [1:0] are ignored and driven as 0.
- burstLength  in  8  number of words minus 1 (0 means 1 word, 255 means 256 words).
- busyOut  out  1  command in progress.
- donePulse  out  1  one cycle, burst completed correctly.
- errorPulse  out  1  one cycle, burst aborted or malformed.
- wordOut  out  32  received data word.
- wordValid  out  1  wordOut valid this cycle. There is no backpressure.
- wordIndex  out  8  index of wordOut within the burst.
- requestTransaction  out  1  bus request to arbiter.
- transactionGranted  in  1  arbiter grant.
- beginTransactionOut  out  1  bus begin strobe.
- addressDataOut  out  32  address during begin.
- byteEnablesOut  out  4  byte enables.
- readNotWriteOut  out  1  read flag.
- burstSizeOut  out  8  burst size.
- endTransactionOut  out  1  initiator abort end.
- addressDataIn  in  32  read data from responder.
- dataValidIn  in  1  read data valid.
- endTransactionIn  in  1  responder end of transaction.
- busErrorIn  in  1  bus error.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - Every output = 0.
  - Counters and latched command cleared.
  - Bus released immediately; no end strobe is issued.
- IDLE:
  - start=1 latches startAddress and burstLength, sets busyOut=1, goes to REQUEST.
  - start while not in IDLE is ignored.
- REQUEST:
  - requestTransaction=1.
  - On transactionGranted=1, go to BEGIN.
  - requestTransaction stays 1 through WAIT and drops in the cycle the block returns to IDLE.
- BEGIN (exactly one cycle):
  - beginTransactionOut=1.
  - addressDataOut={addr[31:2],2'b00}.
  - byteEnablesOut=4'hF, readNotWriteOut=1, burstSizeOut=burstLength.
  - Next state WAIT.
  - In all other states these four outputs are 0.
- WAIT:
  - Each dataValidIn=1 registers addressDataIn into wordOut. wordValid=1 and wordIndex=beat count one cycle later (latency 1), then beat count increments.
  - Beats beyond burstLength+1 are not forwarded and set an overrun flag.
  - On endTransactionIn=1 (checked after the same-cycle dataValid is counted): go to IDLE. Pulse donePulse if count == burstLength+1 and no overrun; otherwise pulse errorPulse.
  - On busErrorIn=1 (takes priority over endTransactionIn and dataValidIn in the same cycle): go to ABORT.
  - Watchdog: reloads on entering WAIT and on each dataValidIn. If it reaches timeoutCycles, go to ABORT.
- ABORT (one cycle):
  - endTransactionOut=1 and errorPulse=1.
  - Next IDLE with requestTransaction=0.
- IDLE re-entry: busyOut=0 and the beat count is cleared. A new start is accepted in the cycle after returning to IDLE.
- Counting rules:
  - The beat counter is 9 bits so the 256-word case does not wrap.
  - wordIndex is the low 8 bits of the counter.
  - donePulse and errorPulse are mutually exclusive and never both asserted.

Decomposition:
- Shared package bus_master_pkg:
  - state enum (IDLE, REQUEST, BEGIN, WAIT, ABORT);
  - constant BYTE_ENABLES_ALL=4'hF;
  - constant MAX_BURST_WORDS=256.
- Sub-module bus_master_watchdog: loadable down-counter with expire output, parameterised by timeoutCycles.
- The FSM, beat counter and data register stay in the top module.

Test Plan:
- start, addr 0x00001006, len 3; grant after 2 cycles; responder returns 4 beats then end → begin with addressData 0x00001004, burstSize 3, BE F; 4 wordValid with indices 0..3; donePulse; requestTransaction drops.
- len 255, 256 beats → wordIndex wraps 255 only on the last beat; donePulse, no error.
- len 3, responder ends after 2 beats → errorPulse, no donePulse; bus outputs return to 0.
- busErrorIn on the 2nd beat → endTransactionOut 1 cycle, errorPulse, IDLE; the 2nd beat is not forwarded.
- Responder silent for 1023 cycles after begin → ABORT: endTransactionOut and errorPulse exactly once.
- Reset asserted mid-WAIT → all outputs 0 same cycle; start 1 cycle after reset release is accepted; start during REQUEST is ignored.
